// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store access controller with sub-word read-modify-write stores
module mem_access_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic             flush,
  input  logic [31:0]      mem_rdata,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_wr,
  output logic             stall,
  output logic [31:0]      load_data,
  output logic             misalign_err,
  output logic [CNT_W-1:0] rmw_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

  state_e            state_q;
  logic [31:0]       lat_addr_q;
  logic [31:0]       lat_wdata_q;
  logic [1:0]        lat_size_q;
  logic [31:0]       rmw_buf_q;
  logic [CNT_W-1:0]  rmw_count_q;

  logic              misalign;
  logic              subword_store;
  logic              mem_wr_raw;
  logic              stall_raw;
  logic [4:0]        lane_shift;
  logic [31:0]       lane_mask;
  logic [31:0]       merged;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;

  // Alignment and sub-word store classification of the incoming request (size 11 behaves as word).
  always_comb begin
    misalign      = 1'b0;
    subword_store = 1'b0;
    if (req_size == 2'b01) begin
      misalign = req_addr[0];
    end else if (req_size[1]) begin
      misalign = (req_addr[1:0] != 2'b00);
    end
    subword_store = req_valid && req_we && !misalign && !req_size[1];
  end

  // Build the merged RMW word: only the target byte/halfword lane is replaced.
  always_comb begin
    lane_shift = '0;
    lane_mask  = '0;
    merged     = rmw_buf_q;
    if (lat_size_q == 2'b00) begin
      lane_shift = {lat_addr_q[1:0], 3'b000};
      lane_mask  = 32'h0000_00ff << lane_shift;
      merged     = (rmw_buf_q & ~lane_mask) | ({24'h0, lat_wdata_q[7:0]} << lane_shift);
    end else begin
      lane_shift = {lat_addr_q[1], 4'b0000};
      lane_mask  = 32'h0000_ffff << lane_shift;
      merged     = (rmw_buf_q & ~lane_mask) | ({16'h0, lat_wdata_q[15:0]} << lane_shift);
    end
  end

  // Output decode: IDLE outputs follow the request directly, RD/WR run off the latched copy.
  always_comb begin
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wr_raw   = 1'b0;
    stall_raw    = 1'b0;
    load_data    = '0;
    misalign_err = 1'b0;
    ld_byte      = mem_rdata[{req_addr[1:0], 3'b000} +: 8];
    ld_half      = req_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          mem_addr  = {req_addr[31:2], 2'b00};
          mem_wdata = req_wdata;
          if (misalign) begin
            misalign_err = !flush;
          end else if (req_we) begin
            if (req_size[1]) begin
              mem_wr_raw = !flush;
            end else begin
              stall_raw = 1'b1;
            end
          end else begin
            unique case (req_size)
              2'b00:   load_data = {{24{req_signed & ld_byte[7]}}, ld_byte};
              2'b01:   load_data = {{16{req_signed & ld_half[15]}}, ld_half};
              default: load_data = mem_rdata;
            endcase
          end
        end
      end
      RD: begin
        mem_addr  = {lat_addr_q[31:2], 2'b00};
        stall_raw = !flush;
      end
      WR: begin
        mem_addr   = {lat_addr_q[31:2], 2'b00};
        mem_wdata  = merged;
        mem_wr_raw = !flush;
      end
      default: ;
    endcase
  end

  // Reset must silence the write strobe and release the pipeline immediately, not at the next edge.
  assign mem_wr    = mem_wr_raw & rst_n;
  assign stall     = stall_raw & rst_n;
  assign rmw_count = rmw_count_q;

  // Sequencer: accept sub-word stores, capture the old word in RD, retire and count in WR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_size_q  <= '0;
      rmw_buf_q   <= '0;
      rmw_count_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (subword_store) begin
            lat_addr_q  <= req_addr;
            lat_wdata_q <= req_wdata;
            lat_size_q  <= req_size;
            state_q     <= RD;
          end
        end
        RD: begin
          if (flush) begin
            state_q <= IDLE;
          end else begin
            rmw_buf_q <= mem_rdata;
            state_q   <= WR;
          end
        end
        WR: begin
          if (!flush && (rmw_count_q != {CNT_W{1'b1}})) begin
            rmw_count_q <= rmw_count_q + CNT_W'(1);
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        stall;
  logic [31:0] load_data;
  logic        misalign_err;
  logic [15:0] rmw_count;

  int errors;
  int checks;

  logic [31:0] mem [0:63];

  mem_access_ctrl #(.CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .flush        (flush),
    .mem_rdata    (mem_rdata),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wr       (mem_wr),
    .stall        (stall),
    .load_data    (load_data),
    .misalign_err (misalign_err),
    .rmw_count    (rmw_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-only data memory with combinational read.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[7:2]] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr[7:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock, then present a request and let it settle before checking.
  task automatic drive(input logic v, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    req_valid = v; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0; flush = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    #12;
    check("rst_stall",     {31'b0, stall}, 32'd0);
    check("rst_mem_wr",    {31'b0, mem_wr}, 32'd0);
    check("rst_count",     {16'b0, rmw_count}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_mem_addr",  mem_addr, 32'd0);
    rst_n = 1'b1;

    // 1: word store then word load
    drive(1, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF);
    check("sw_mem_wr", {31'b0, mem_wr}, 32'd1);
    check("sw_stall",  {31'b0, stall}, 32'd0);
    check("sw_wdata",  mem_wdata, 32'hDEADBEEF);
    check("sw_addr",   mem_addr, 32'h10);
    drive(1, 0, 2'b10, 0, 32'h10, 32'h0);
    check("lw_0x10",   load_data, 32'hDEADBEEF);
    check("lw_mem_wr", {31'b0, mem_wr}, 32'd0);

    // 2: sb 0xAA at 0x21 over 0x11223344
    drive(1, 1, 2'b10, 0, 32'h20, 32'h11223344);
    drive(1, 1, 2'b00, 0, 32'h21, 32'h000000AA);
    check("sb_acc_stall", {31'b0, stall}, 32'd1);
    check("sb_acc_wr",    {31'b0, mem_wr}, 32'd0);
    step();
    check("sb_rd_stall", {31'b0, stall}, 32'd1);
    check("sb_rd_wr",    {31'b0, mem_wr}, 32'd0);
    check("sb_rd_addr",  mem_addr, 32'h20);
    step();
    check("sb_wr_stall", {31'b0, stall}, 32'd0);
    check("sb_wr_wr",    {31'b0, mem_wr}, 32'd1);
    check("sb_wr_data",  mem_wdata, 32'h1122AA44);
    drive(1, 0, 2'b10, 0, 32'h20, 32'h0);
    check("sb_count",   {16'b0, rmw_count}, 32'd1);
    check("sb_readback", load_data, 32'h1122AA44);

    // 3: load extraction and extension
    drive(1, 1, 2'b10, 0, 32'h20, 32'h80FF7F01);
    drive(1, 0, 2'b00, 1, 32'h22, 32'h0); check("lb_0x22",  load_data, 32'hFFFFFFFF);
    drive(1, 0, 2'b00, 0, 32'h22, 32'h0); check("lbu_0x22", load_data, 32'h000000FF);
    drive(1, 0, 2'b01, 1, 32'h22, 32'h0); check("lh_0x22",  load_data, 32'hFFFF80FF);
    drive(1, 0, 2'b01, 0, 32'h20, 32'h0); check("lhu_0x20", load_data, 32'h00007F01);
    drive(1, 0, 2'b00, 1, 32'h21, 32'h0); check("lb_0x21",  load_data, 32'h0000007F);
    drive(1, 0, 2'b00, 1, 32'h23, 32'h0); check("lb_0x23",  load_data, 32'hFFFFFF80);
    drive(1, 0, 2'b00, 0, 32'h23, 32'h0); check("lbu_0x23", load_data, 32'h00000080);
    drive(1, 0, 2'b11, 1, 32'h20, 32'h0); check("lw_sz11",  load_data, 32'h80FF7F01);

    // 4: misaligned accesses are suppressed
    drive(1, 1, 2'b10, 0, 32'h30, 32'hCAFEF00D);
    drive(1, 1, 2'b01, 0, 32'h31, 32'h0000BEEF);
    check("sh31_err",   {31'b0, misalign_err}, 32'd1);
    check("sh31_wr",    {31'b0, mem_wr}, 32'd0);
    check("sh31_stall", {31'b0, stall}, 32'd0);
    drive(1, 1, 2'b10, 0, 32'h32, 32'h12345678);
    check("sw32_err", {31'b0, misalign_err}, 32'd1);
    check("sw32_wr",  {31'b0, mem_wr}, 32'd0);
    drive(1, 0, 2'b10, 0, 32'h32, 32'h0);
    check("lw32_err",  {31'b0, misalign_err}, 32'd1);
    check("lw32_data", load_data, 32'd0);
    flush = 1'b1;
    drive(1, 1, 2'b10, 0, 32'h32, 32'h12345678);
    check("flush_idle_err", {31'b0, misalign_err}, 32'd0);
    check("flush_idle_wr",  {31'b0, mem_wr}, 32'd0);
    flush = 1'b0;
    drive(1, 0, 2'b10, 0, 32'h30, 32'h0);
    check("mis_mem_intact", load_data, 32'hCAFEF00D);

    // 5: sh flushed in RD, then a clean sh on the upper lane
    drive(1, 1, 2'b10, 0, 32'h40, 32'h12345678);
    drive(1, 1, 2'b01, 0, 32'h40, 32'h0000BEEF);
    check("sh_acc_stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1; flush = 1'b1; #1;
    check("flush_rd_wr",    {31'b0, mem_wr}, 32'd0);
    check("flush_rd_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1; flush = 1'b0;
    req_valid = 1'b0; #1;
    check("flush_idle_stall", {31'b0, stall}, 32'd0);
    check("flush_idle_addr",  mem_addr, 32'd0);
    check("flush_count",      {16'b0, rmw_count}, 32'd1);
    drive(1, 0, 2'b10, 0, 32'h40, 32'h0);
    check("flush_mem_intact", load_data, 32'h12345678);
    drive(1, 1, 2'b01, 0, 32'h42, 32'h0000BEEF);
    step();
    step();
    check("sh42_wr",   {31'b0, mem_wr}, 32'd1);
    check("sh42_data", mem_wdata, 32'hBEEF5678);
    drive(1, 0, 2'b10, 0, 32'h40, 32'h0);
    check("sh42_count",    {16'b0, rmw_count}, 32'd2);
    check("sh42_readback", load_data, 32'hBEEF5678);

    // 6: reset asserted during the WR cycle
    drive(1, 1, 2'b10, 0, 32'h50, 32'h55667788);
    drive(1, 1, 2'b00, 0, 32'h53, 32'h00000099);
    step();
    step();
    check("rstwr_pre_wr", {31'b0, mem_wr}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstwr_wr",    {31'b0, mem_wr}, 32'd0);
    check("rstwr_stall", {31'b0, stall}, 32'd0);
    check("rstwr_count", {16'b0, rmw_count}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b1;
    drive(1, 0, 2'b10, 0, 32'h50, 32'h0);
    check("rstwr_mem_intact", load_data, 32'h55667788);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
